csi2_tx_packetizer: RTL

- Byte-clock-domain MIPI CSI-2 packet transmitter for 2 data lanes; the transmit counterpart of the camera receive path.
- Turns frame/line requests and a 16-bit pixel stream into HS bursts: sync byte, packet header with ECC, payload, CRC-16, trail.
- Drives the per-lane byte serializer/PHY glue. Used as a loopback source for receiver bring-up and for camera emulation.

---
 rtl/csi2_tx_packetizer_if.sv | 30 +++
 rtl/csi2_tx_packetizer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_tx_packetizer_if.sv
// Request, pixel and lane-side signals of the CSI-2 transmit packetizer.
// The packetizer itself is the slave; the frame/pixel source and the PHY
// glue together form the master side.
interface csi2_tx_packetizer_if;
  logic        fs_req;
  logic        line_req;
  logic        fe_req;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  lane0_byte;
  logic [7:0]  lane1_byte;
  logic        hs_req;
  logic        hs_valid;
  logic        busy;
  logic        underrun;
  logic [15:0] frame_num;

  modport master (
    output fs_req, line_req, fe_req, pix_data, pix_valid,
    input  pix_ready, lane0_byte, lane1_byte, hs_req, hs_valid,
           busy, underrun, frame_num
  );

  modport slave (
    input  fs_req, line_req, fe_req, pix_data, pix_valid,
    output pix_ready, lane0_byte, lane1_byte, hs_req, hs_valid,
           busy, underrun, frame_num
  );
endinterface

// File: rtl/csi2_tx_packetizer.sv
// Two-lane MIPI CSI-2 HS packet transmitter in the byte clock domain.
// Builds FS/FE short packets and RAW long packets: HS prepare, sync byte,
// header with ECC, payload with CRC-16, then trail, one byte per lane per cycle.
module csi2_tx_packetizer #(
  parameter int unsigned LINE_BYTES      = 1280,
  parameter logic [7:0]  DATA_TYPE       = 8'h2A,
  parameter logic [1:0]  VC              = 2'd0,
  parameter int unsigned HS_PREP_CYCLES  = 4,
  parameter int unsigned HS_TRAIL_CYCLES = 4
) (
  input logic                 sys_clk,
  input logic                 reset,
  csi2_tx_packetizer_if.slave tx_if
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREP    = 3'd1,
    ST_SYNC    = 3'd2,
    ST_HDR0    = 3'd3,
    ST_HDR1    = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CRC     = 3'd6,
    ST_TRAIL   = 3'd7
  } state_e;

  localparam logic [15:0] PREP_LAST  = 16'(HS_PREP_CYCLES - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(HS_TRAIL_CYCLES - 1);
  localparam logic [15:0] PAY_LAST   = 16'(LINE_BYTES / 2 - 1);
  localparam logic [15:0] WC_LONG    = 16'(LINE_BYTES);
  localparam logic [7:0]  DI_FS      = {VC, 6'h00};
  localparam logic [7:0]  DI_FE      = {VC, 6'h01};
  localparam logic [7:0]  DI_LONG    = {VC, DATA_TYPE[5:0]};
  localparam logic [7:0]  SYNC_BYTE  = 8'hB8;

  // CSI-2 header ECC: 6-bit Hamming over {WC, DI}, DI[0] is D0.
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Reflected CRC-16 (0x8408) advanced by one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ 16'h8408;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  pend_q;       // {fe, line, fs}
  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic        is_long_q;
  logic [15:0] crc_q;
  logic [15:0] frame_num_q;
  logic        hs_req_q;
  logic        hs_valid_q;
  logic        pix_ready_q;
  logic        busy_q;
  logic        underrun_q;
  logic [7:0]  lane0_q;
  logic [7:0]  lane1_q;

  logic [2:0]  pend_eff_s;
  logic [7:0]  pay0_s;
  logic [7:0]  pay1_s;
  logic [15:0] crc_next_s;
  logic [7:0]  ecc_s;
  logic [15:0] fn_inc_s;

  // A request pulse arriving while idle is serviced on the same edge it is seen.
  assign pend_eff_s = pend_q | {tx_if.fe_req, tx_if.line_req, tx_if.fs_req};
  // Missing pixel words are replaced by zero bytes so the burst never stalls.
  assign pay0_s     = tx_if.pix_valid ? tx_if.pix_data[7:0]  : 8'h00;
  assign pay1_s     = tx_if.pix_valid ? tx_if.pix_data[15:8] : 8'h00;
  assign crc_next_s = crc16_byte(crc16_byte(crc_q, pay0_s), pay1_s);
  assign ecc_s      = ecc_calc({wc_q, di_q});
  // Frame number 0 is reserved, so the counter skips it on wrap.
  assign fn_inc_s   = (frame_num_q == 16'hFFFF) ? 16'h0001 : (frame_num_q + 16'h0001);

  // Packet sequencer: state, counters, header/CRC registers and registered outputs.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'h0000;
      pend_q      <= 3'b000;
      di_q        <= 8'h00;
      wc_q        <= 16'h0000;
      is_long_q   <= 1'b0;
      crc_q       <= 16'hFFFF;
      frame_num_q <= 16'h0000;
      hs_req_q    <= 1'b0;
      hs_valid_q  <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      lane0_q     <= 8'h00;
      lane1_q     <= 8'h00;
    end else begin
      pend_q <= pend_eff_s;
      case (state_q)
        ST_IDLE: begin
          if (pend_eff_s != 3'b000) begin
            state_q  <= ST_PREP;
            cnt_q    <= PREP_LAST;
            hs_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
          if (pend_eff_s[0]) begin
            frame_num_q <= fn_inc_s;
            di_q        <= DI_FS;
            wc_q        <= fn_inc_s;
            is_long_q   <= 1'b0;
            pend_q      <= pend_eff_s & 3'b110;
          end else if (pend_eff_s[1]) begin
            di_q      <= DI_LONG;
            wc_q      <= WC_LONG;
            is_long_q <= 1'b1;
            pend_q    <= pend_eff_s & 3'b101;
          end else if (pend_eff_s[2]) begin
            di_q      <= DI_FE;
            wc_q      <= frame_num_q;
            is_long_q <= 1'b0;
            pend_q    <= pend_eff_s & 3'b011;
          end
        end
        ST_PREP: begin
          if (cnt_q == 16'h0000) begin
            state_q    <= ST_SYNC;
            hs_valid_q <= 1'b1;
            lane0_q    <= SYNC_BYTE;
            lane1_q    <= SYNC_BYTE;
          end else begin
            cnt_q <= cnt_q - 16'h0001;
          end
        end
        ST_SYNC: begin
          state_q <= ST_HDR0;
          lane0_q <= di_q;
          lane1_q <= wc_q[7:0];
        end
        ST_HDR0: begin
          state_q <= ST_HDR1;
          lane0_q <= wc_q[15:8];
          lane1_q <= ecc_s;
        end
        ST_HDR1: begin
          crc_q <= 16'hFFFF;
          if (is_long_q) begin
            state_q     <= ST_PAYLOAD;
            cnt_q       <= PAY_LAST;
            pix_ready_q <= 1'b1;
            lane0_q     <= 8'h00;
            lane1_q     <= 8'h00;
          end else begin
            state_q <= ST_TRAIL;
            cnt_q   <= TRAIL_LAST;
            lane0_q <= {8{~lane0_q[7]}};
            lane1_q <= {8{~lane1_q[7]}};
          end
        end
        ST_PAYLOAD: begin
          crc_q <= crc_next_s;
          if (!tx_if.pix_valid) begin
            underrun_q <= 1'b1;
          end
          if (cnt_q == 16'h0000) begin
            state_q     <= ST_CRC;
            pix_ready_q <= 1'b0;
            lane0_q     <= crc_next_s[7:0];
            lane1_q     <= crc_next_s[15:8];
          end else begin
            cnt_q <= cnt_q - 16'h0001;
          end
        end
        ST_CRC: begin
          state_q <= ST_TRAIL;
          cnt_q   <= TRAIL_LAST;
          lane0_q <= {8{~lane0_q[7]}};
          lane1_q <= {8{~lane1_q[7]}};
        end
        ST_TRAIL: begin
          if (cnt_q == 16'h0000) begin
            state_q    <= ST_IDLE;
            hs_req_q   <= 1'b0;
            hs_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            lane0_q    <= 8'h00;
            lane1_q    <= 8'h00;
          end else begin
            cnt_q <= cnt_q - 16'h0001;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          hs_req_q    <= 1'b0;
          hs_valid_q  <= 1'b0;
          pix_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          lane0_q     <= 8'h00;
          lane1_q     <= 8'h00;
        end
      endcase
    end
  end

  // Payload bytes go straight from the pixel word to the lanes in the cycle it is consumed.
  assign tx_if.lane0_byte = (state_q == ST_PAYLOAD) ? pay0_s : lane0_q;
  assign tx_if.lane1_byte = (state_q == ST_PAYLOAD) ? pay1_s : lane1_q;
  assign tx_if.pix_ready  = pix_ready_q;
  assign tx_if.hs_req     = hs_req_q;
  assign tx_if.hs_valid   = hs_valid_q;
  assign tx_if.busy       = busy_q;
  assign tx_if.underrun   = underrun_q;
  assign tx_if.frame_num  = frame_num_q;

endmodule
